// File: rtl/lector_mante.sv
// lector_mante: loadable down-counter with IDLE/CUENTA/AVISO handshake FSM.
// Latency: load and decrement are visible on data_output one edge after being sampled.
// Completion is held in AVISO until ack; optional low-count alarm under `MANTE_ALARM_EN.
module lector_mante #(
   parameter logic [7:0] ALARM_LEVEL = 8'd5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] data_input,
   input  logic       load,
   input  logic       enable,
   input  logic       ack,
   output logic [7:0] data_output,
   output logic       busy,
   output logic       done,
   output logic       alarm
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] CUENTA = 2'd1;
   localparam logic [1:0] AVISO  = 2'd2;

   logic [1:0] state_q, state_d;
   logic [7:0] cnt_q, cnt_d;

   // Next-state and next-count: load beats enable; AVISO only listens to ack.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (load) begin
               cnt_d   = data_input;
               state_d = (data_input != 8'd0) ? CUENTA : AVISO;
            end
         end
         CUENTA: begin
            if (load) begin
               cnt_d   = data_input;
               state_d = (data_input != 8'd0) ? CUENTA : AVISO;
            end else if (enable && (cnt_q != 8'd0)) begin
               // Zero guard keeps the 0 -> FF wrap unreachable even from a corrupt state.
               cnt_d = cnt_q - 8'd1;
               if (cnt_q == 8'd1) begin
                  state_d = AVISO;
               end
            end
         end
         AVISO: begin
            if (ack) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and count registers with synchronous reset that overrides every input.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign data_output = cnt_q;
   assign busy        = (state_q == CUENTA);
   assign done        = (state_q == AVISO);

`ifdef MANTE_ALARM_EN
   // Warn while counting once the count is within ALARM_LEVEL of completion.
   assign alarm = (state_q == CUENTA) && (cnt_q >= 8'd1) && (cnt_q <= ALARM_LEVEL);
`else
   assign alarm = 1'b0;
`endif

endmodule

// File: doc/lector_mante.md
LECTOR_MANTE -- requirements
Module: lector_mante

Interface
REQ-001 SHALL provide parameter ALARM_LEVEL, default 8'd5, meaning the count at or below which the alarm asserts.
REQ-002 SHALL provide port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL provide port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL provide port data_input  input  8  initial count to load.
REQ-005 SHALL provide port load  input  1  load request, sampled in IDLE and CUENTA.
REQ-006 SHALL provide port enable  input  1  decrement strobe, sampled in CUENTA.
REQ-007 SHALL provide port ack  input  1  consumer acknowledge of completion, sampled in AVISO.
REQ-008 SHALL provide port data_output  output  8  current count register.
REQ-009 SHALL provide port busy  output  1  high while the FSM is in CUENTA.
REQ-010 SHALL provide port done  output  1  high while the FSM is in AVISO.
REQ-011 SHALL provide port alarm  output  1  low-count warning (see Configuration).

Function
REQ-012 SHALL implement a three-state FSM: IDLE, CUENTA, AVISO; busy and done SHALL be decoded from registered state only.
REQ-013 IDLE: load=1 -> data_output <= data_input on the next edge; next state CUENTA if data_input != 0, AVISO if data_input == 0.
REQ-014 IDLE: load=0 -> data_output holds, state holds; enable and ack ignored.
REQ-015 CUENTA: load=1 -> restart exactly as REQ-013 (load has priority over enable).
REQ-016 CUENTA: load=0, enable=1 -> data_output <= data_output - 1 (mod 256); if data_output == 1, next state AVISO.
REQ-017 CUENTA: load=0, enable=0 -> data_output and state hold.
REQ-018 Decrement latency SHALL be one cycle: value visible on data_output the edge after enable is sampled.
REQ-019 data_output SHALL never be decremented from 0; wrap to 8'hFF SHALL be unreachable.
REQ-020 AVISO: done=1, busy=0, data_output holds; ack=1 -> next state IDLE; load and enable ignored, including when simultaneous with ack.
REQ-021 AVISO: ack=0 -> state holds indefinitely.
REQ-022 done SHALL deassert the cycle after ack is sampled; a new load SHALL be accepted at the earliest one cycle after that.

Reset
REQ-023 reset=1 at a rising edge SHALL force state IDLE, data_output 8'h00, busy 0, done 0, alarm 0, overriding all other inputs.
REQ-024 reset asserted mid-count or in AVISO SHALL abandon the operation with no completion pulse.
REQ-025 No output SHALL change asynchronously with reset.

Configuration
REQ-026 Macro MANTE_ALARM_EN defined: alarm SHALL be 1 exactly when state is CUENTA and 1 <= data_output <= ALARM_LEVEL, else 0.
REQ-027 Macro MANTE_ALARM_EN undefined: alarm port SHALL remain present and be driven constant 0; no compare logic instantiated.
REQ-028 All other behaviour SHALL be identical with and without MANTE_ALARM_EN.

Verification
REQ-029 Reset, then load=1 data_input=8'd3, enable=1 continuously -> data_output 3,2,1,0 on successive edges; busy 1 for 3 cycles; done 1 from the cycle data_output reaches 0.
REQ-030 In AVISO hold ack=0 for 10 cycles -> done stays 1, data_output stays 0; then ack=1 -> done 0 and state IDLE next edge.
REQ-031 load=1 data_input=8'd0 in IDLE -> next edge done=1, busy=0, data_output=0, no wrap on subsequent enable pulses.
REQ-032 Load 8'd20, decrement to 12, then load=1 enable=1 same cycle with data_input=8'd7 -> data_output=7, busy stays 1.
REQ-033 Load 8'd200, decrement to 150, assert reset -> next edge data_output=0, busy=0, done=0; ack pulses afterwards have no effect.
REQ-034 With MANTE_ALARM_EN, load 8'd8, enable continuous -> alarm 0 at 8,7,6, alarm 1 at 5..1, alarm 0 at 0/AVISO; without macro alarm stays 0 throughout.
